// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding req/ack fetch
// against instruction memory and presents instruction/pc/valid to decode.
module fetch_stage #(
  parameter int unsigned                   PC_WIDTH          = 32,
  parameter int unsigned                   INSTRUCTION_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]           RESET_PC          = '0,
  parameter logic [INSTRUCTION_WIDTH-1:0]  NOP_WORD          = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall_pipeline,
  input  logic                          is_jump,
  input  logic [PC_WIDTH-1:0]           jump_addr,
  input  logic                          branch_taken,
  input  logic [PC_WIDTH-1:0]           branch_addr,
  output logic                          imem_req,
  output logic [PC_WIDTH-1:0]           imem_addr,
  input  logic                          imem_ack,
  input  logic [INSTRUCTION_WIDTH-1:0]  imem_rdata,
  output logic [INSTRUCTION_WIDTH-1:0]  instruction,
  output logic [PC_WIDTH-1:0]           pc,
  output logic                          valid
);

  // state      | meaning
  // ST_REQ     | idle, issue a request for pc_reg this cycle
  // ST_WAIT    | request outstanding, its response is wanted
  // ST_HOLD    | response parked in the skid buffer, decode stalled
  // ST_DISCARD | request outstanding but squashed by a redirect
  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DISCARD} state_e;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  state_e                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_reg_q, pc_reg_d;
  logic [PC_WIDTH-1:0]            req_pc_q, req_pc_d;
  logic [INSTRUCTION_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [PC_WIDTH-1:0]            skid_pc_q, skid_pc_d;
  logic                           skid_full_q, skid_full_d;
  logic [INSTRUCTION_WIDTH-1:0]   instr_q, instr_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d;
  logic                           valid_q, valid_d;

  logic                           redirect;
  logic [PC_WIDTH-1:0]            target;
  logic                           delivered;

  // A jump from decode is meaningless while decode is frozen; a branch always flushes.
  assign redirect = branch_taken | (is_jump & ~stall_pipeline);
  assign target   = branch_taken ? branch_addr : jump_addr;

  assign imem_req  = (state_q == ST_REQ) && !redirect && !skid_full_q;
  assign imem_addr = pc_reg_q;

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign valid       = valid_q;

  always_comb begin
    state_d     = state_q;
    pc_reg_d    = pc_reg_q;
    req_pc_d    = req_pc_q;
    skid_data_d = skid_data_q;
    skid_pc_d   = skid_pc_q;
    skid_full_d = skid_full_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    delivered   = 1'b0;

    if (redirect) begin
      pc_reg_d    = target;
      skid_full_d = 1'b0;
      valid_d     = 1'b0;
      instr_d     = NOP_WORD;
      // An in-flight request must still be drained; its data is dropped on arrival.
      if ((state_q == ST_WAIT) || (state_q == ST_DISCARD)) begin
        state_d = imem_ack ? ST_REQ : ST_DISCARD;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      unique case (state_q)
        ST_REQ: begin
          if (!skid_full_q) begin
            req_pc_d = pc_reg_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            pc_reg_d = req_pc_q + PC_ONE;
            if (!stall_pipeline) begin
              instr_d   = imem_rdata;
              pc_d      = req_pc_q;
              valid_d   = 1'b1;
              delivered = 1'b1;
              state_d   = ST_REQ;
            end else begin
              skid_data_d = imem_rdata;
              skid_pc_d   = req_pc_q;
              skid_full_d = 1'b1;
              state_d     = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall_pipeline) begin
            instr_d     = skid_data_q;
            pc_d        = skid_pc_q;
            valid_d     = 1'b1;
            delivered   = 1'b1;
            skid_full_d = 1'b0;
            state_d     = ST_REQ;
          end
        end
        ST_DISCARD: begin
          if (imem_ack) begin
            state_d = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase

      if (!stall_pipeline && !delivered) begin
        valid_d = 1'b0;
        instr_d = NOP_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_REQ;
      pc_reg_q    <= RESET_PC;
      req_pc_q    <= RESET_PC;
      skid_data_q <= NOP_WORD;
      skid_pc_q   <= '0;
      skid_full_q <= 1'b0;
      instr_q     <= NOP_WORD;
      pc_q        <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_reg_q    <= pc_reg_d;
      req_pc_q    <= req_pc_d;
      skid_data_q <= skid_data_d;
      skid_pc_q   <= skid_pc_d;
      skid_full_q <= skid_full_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

endmodule
